// File: rtl/dac_serial_responder.sv
// Serial responder for the 16-bit DAC frame link: synchronizes cs/sclk/sdi, shifts frames MSB-first, presents ctrl+sample.
// Optional error counter (err_count/err_clr) built when DAC_RESP_ERR_COUNT_EN is defined.
module dac_serial_responder #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned CTRL_W      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              sdi,
  output logic [DATA_W-1:0] pdo,
  output logic [CTRL_W-1:0] ctrl,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
`ifdef DAC_RESP_ERR_COUNT_EN
  ,
  input  logic              err_clr,
  output logic [7:0]        err_count
`endif
);

  localparam int unsigned FRAME_W = DATA_W + CTRL_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdi_sync_q, live_q;
  logic                   cs_d1_q, sclk_d1_q, armed_q;
  logic                   cs_s, sclk_s, sdi_s;
  logic                   sclk_rise, cs_rise;

  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  pdo_q, pdo_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign cs_rise   = cs_s & ~cs_d1_q;

  // Synchronizers; live_q marks when cs_s reflects a real pin sample rather than the reset fill,
  // so armed_q only sets once cs has genuinely been seen high after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      live_q      <= '0;
      cs_d1_q     <= 1'b1;
      sclk_d1_q   <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      live_q      <= {live_q[SYNC_STAGES-2:0], 1'b1};
      cs_d1_q     <= cs_s;
      sclk_d1_q   <= sclk_s;
      armed_q     <= armed_q | (live_q[SYNC_STAGES-1] & cs_s);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (armed_q && !cs_s) state_d = S_SHIFT;
      S_SHIFT: if (cs_rise) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-values; cs_rise takes priority over a coincident sclk_rise.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    pdo_d   = pdo_q;
    ctrl_d  = ctrl_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (armed_q && !cs_s) begin
          shreg_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (!cs_rise) begin
          busy_d = 1'b1;
          if (sclk_rise) begin
            shreg_d = {shreg_q[FRAME_W-2:0], sdi_s};
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (cnt_q == CNT_FULL) begin
          ctrl_d  = shreg_q[FRAME_W-1:DATA_W];
          pdo_d   = shreg_q[DATA_W-1:0];
          valid_d = 1'b1;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      pdo_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      pdo_q   <= pdo_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign pdo       = pdo_q;
  assign ctrl      = ctrl_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

`ifdef DAC_RESP_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // Saturating error tally; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             err_count_q <= 8'h00;
    else if (err_clr)                       err_count_q <= 8'h00;
    else if (ferr_q && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'h01;
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_dac_serial_responder.sv
// Directed bench for dac_serial_responder; clk runs at 8x sclk. Covers DAC_RESP_ERR_COUNT_EN when defined.
module tb_dac_serial_responder;

  logic        clk, reset, sclk, cs, sdi;
  logic [11:0] pdo;
  logic [3:0]  ctrl;
  logic        valid, frame_err, busy;
`ifdef DAC_RESP_ERR_COUNT_EN
  logic        err_clr;
  logic [7:0]  err_count;
`endif

  int tests  = 0;
  int failed = 0;

  dac_serial_responder dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .sdi       (sdi),
    .pdo       (pdo),
    .ctrl      (ctrl),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef DAC_RESP_ERR_COUNT_EN
    ,
    .err_clr   (err_clr),
    .err_count (err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse tally and capture, plus exclusivity / no-back-to-back tracking.
  int          n_valid = 0;
  int          n_ferr  = 0;
  int          n_viol  = 0;
  logic        prev_pulse = 1'b0;
  logic [11:0] cap_pdo  [0:15];
  logic [3:0]  cap_ctrl [0:15];

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      cap_pdo[n_valid[3:0]]  = pdo;
      cap_ctrl[n_valid[3:0]] = ctrl;
      n_valid++;
    end
    if (frame_err === 1'b1) n_ferr++;
    if ((valid === 1'b1 && frame_err === 1'b1) || (prev_pulse && (valid === 1'b1 || frame_err === 1'b1)))
      n_viol++;
    prev_pulse = (valid === 1'b1) || (frame_err === 1'b1);
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 16) ? w[15-i] : 1'b0;
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(2);
  endtask

  task automatic frame(input logic [15:0] w, input int nbits);
    cs = 1'b0;
    tick(4);
    shift_bits(w, nbits);
    cs = 1'b1;
    tick(10);
  endtask

  int v0, e0;

  initial begin
    reset = 1'b0; cs = 1'b1; sclk = 1'b0; sdi = 1'b0;
`ifdef DAC_RESP_ERR_COUNT_EN
    err_clr = 1'b0;
`endif
    tick(3);
    check("rst_pdo", 32'(pdo), 32'h0);
    check("rst_ctrl", 32'(ctrl), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    tick(4);

    // Single good frame with latency check
    v0 = n_valid; e0 = n_ferr;
    cs = 1'b0;
    tick(4);
    shift_bits(16'h3A5C, 16);
    check("busy_in_frame", 32'(busy), 32'h1);
    cs = 1'b1;
    tick(3);
    check("lat_early", 32'(valid), 32'h0);
    tick(1);
    check("lat_valid", 32'(valid), 32'h1);
    tick(1);
    check("lat_one_clk", 32'(valid), 32'h0);
    tick(6);
    check("f1_nvalid", 32'(n_valid - v0), 32'd1);
    check("f1_nferr", 32'(n_ferr - e0), 32'd0);
    check("f1_ctrl", 32'(ctrl), 32'h3);
    check("f1_pdo", 32'(pdo), 32'hA5C);
    check("f1_busy_idle", 32'(busy), 32'h0);

    // Short frame
    v0 = n_valid; e0 = n_ferr;
    frame(16'h1234, 15);
    check("short_nvalid", 32'(n_valid - v0), 32'd0);
    check("short_nferr", 32'(n_ferr - e0), 32'd1);
    check("short_pdo", 32'(pdo), 32'hA5C);
    check("short_ctrl", 32'(ctrl), 32'h3);

    // Long frames: 17 edges and 34 edges (saturation must hold)
    v0 = n_valid; e0 = n_ferr;
    frame(16'h1234, 17);
    check("long17_nvalid", 32'(n_valid - v0), 32'd0);
    check("long17_nferr", 32'(n_ferr - e0), 32'd1);
    v0 = n_valid; e0 = n_ferr;
    frame(16'h1234, 34);
    check("long34_nvalid", 32'(n_valid - v0), 32'd0);
    check("long34_nferr", 32'(n_ferr - e0), 32'd1);
    check("long_pdo", 32'(pdo), 32'hA5C);

    // Back-to-back frames with cs high for 2 clk
    v0 = n_valid; e0 = n_ferr;
    cs = 1'b0;
    tick(4);
    shift_bits(16'h1FFF, 16);
    cs = 1'b1;
    tick(2);
    cs = 1'b0;
    tick(4);
    shift_bits(16'h2001, 16);
    cs = 1'b1;
    tick(10);
    check("b2b_nvalid", 32'(n_valid - v0), 32'd2);
    check("b2b_nferr", 32'(n_ferr - e0), 32'd0);
    check("b2b_pdo0", 32'(cap_pdo[v0[3:0]]), 32'hFFF);
    check("b2b_ctrl0", 32'(cap_ctrl[v0[3:0]]), 32'h1);
    check("b2b_pdo1", 32'(cap_pdo[4'(v0 + 1)]), 32'h001);
    check("b2b_ctrl1", 32'(cap_ctrl[4'(v0 + 1)]), 32'h2);
    check("b2b_pdo_now", 32'(pdo), 32'h001);

    // Reset mid-frame, release with cs low, stray edges ignored, then a fresh frame
    v0 = n_valid; e0 = n_ferr;
    cs = 1'b0;
    tick(4);
    shift_bits(16'hFFFF, 8);
    reset = 1'b0;
    tick(2);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_pdo", 32'(pdo), 32'h0);
    reset = 1'b1;
    tick(6);
    check("postrst_busy", 32'(busy), 32'h0);
    shift_bits(16'hFFFF, 8);
    check("postrst_ignored_busy", 32'(busy), 32'h0);
    cs = 1'b1;
    tick(6);
    check("abort_nvalid", 32'(n_valid - v0), 32'd0);
    check("abort_nferr", 32'(n_ferr - e0), 32'd0);
    frame(16'h0800, 16);
    check("fresh_nvalid", 32'(n_valid - v0), 32'd1);
    check("fresh_nferr", 32'(n_ferr - e0), 32'd0);
    check("fresh_pdo", 32'(pdo), 32'h800);
    check("fresh_ctrl", 32'(ctrl), 32'h0);

`ifdef DAC_RESP_ERR_COUNT_EN
    check("ec_after_rst", 32'(err_count), 32'h0);
    e0 = n_ferr;
    for (int k = 0; k < 300; k++) begin
      cs = 1'b0;
      tick(3);
      cs = 1'b1;
      tick(6);
    end
    check("ec_nferr300", 32'(n_ferr - e0), 32'd300);
    check("ec_saturate", 32'(err_count), 32'hFF);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ec_clear", 32'(err_count), 32'h0);
    cs = 1'b0;
    tick(3);
    cs = 1'b1;
    tick(8);
    check("ec_one", 32'(err_count), 32'h1);
    cs = 1'b0;
    tick(3);
    cs = 1'b1;
    tick(4);
    check("ec_ferr_now", 32'(frame_err), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ec_clr_wins", 32'(err_count), 32'h0);
    tick(4);
    check("ec_stays0", 32'(err_count), 32'h0);
`endif

    check("pulse_rules", 32'(n_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
